// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file writeback controller.
package rf_ctrl_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned RAW  = $clog2(NREG);

    typedef enum logic {REQ_ALU, REQ_MEM} wb_req_t;

    typedef logic [RAW-1:0]  reg_idx_t;
    typedef logic [XLEN-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; bit 0 is the ALU request, bit 1 the MEM request.
module rr_arbiter2
    import rf_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    wb_req_t last_grant_q, last_grant_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= REQ_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = (last_grant_q == REQ_MEM) ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (advance_i) begin
            last_grant_d = gnt_o[0] ? REQ_ALU : REQ_MEM;
        end
    end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Owns the register-file write port: arbitrates ALU/MEM writebacks and keeps a busy
// scoreboard that stalls issue on RAW/WAW hazards against in-flight destinations.
module rf_writeback_ctrl
    import rf_ctrl_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_valid_i,
    input  logic [RAW-1:0]  issue_rs1_i,
    input  logic [RAW-1:0]  issue_rs2_i,
    input  logic [RAW-1:0]  issue_rd_i,
    output logic            issue_stall_o,
    input  logic            alu_valid_i,
    input  logic [RAW-1:0]  alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    output logic            alu_ready_o,
    input  logic            mem_valid_i,
    input  logic [RAW-1:0]  mem_rd_i,
    input  logic [XLEN-1:0] mem_data_i,
    output logic            mem_ready_o,
    output logic            rf_we_o,
    output logic [RAW-1:0]  rf_ws_o,
    output logic [XLEN-1:0] rf_wd_o,
    output logic [NREG-1:0] busy_o
);

    logic [1:0]      gnt;
    logic            alu_hs, mem_hs, wb_hs, issue_acc;
    reg_idx_t        wb_rd;
    reg_data_t       wb_data;

    logic            rf_we_q, rf_we_d;
    reg_idx_t        rf_ws_q, rf_ws_d;
    reg_data_t       rf_wd_q, rf_wd_d;
    logic [NREG-1:0] busy_q, busy_d;

    rr_arbiter2 u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     ({mem_valid_i, alu_valid_i}),
        .advance_i (wb_hs),
        .gnt_o     (gnt)
    );

    // Ready is a pure grant: the write port never backpressures.
    assign alu_ready_o = gnt[0] & ~rst_i;
    assign mem_ready_o = gnt[1] & ~rst_i;
    assign alu_hs      = alu_valid_i & alu_ready_o;
    assign mem_hs      = mem_valid_i & mem_ready_o;
    assign wb_hs       = alu_hs | mem_hs;
    assign wb_rd       = alu_hs ? alu_rd_i : mem_rd_i;
    assign wb_data     = alu_hs ? alu_data_i : mem_data_i;

    assign issue_stall_o = issue_valid_i &
                           (busy_q[issue_rs1_i] | busy_q[issue_rs2_i] | busy_q[issue_rd_i]);
    assign issue_acc     = issue_valid_i & ~issue_stall_o;

    always_comb begin
        rf_we_d = 1'b0;
        rf_ws_d = rf_ws_q;
        rf_wd_d = rf_wd_q;
        if (wb_hs) begin
            rf_we_d = (wb_rd != '0);
            rf_ws_d = wb_rd;
            rf_wd_d = wb_data;
        end
    end

    // Clear lands on the same edge the register file commits; a set on that edge wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_ws_q] = 1'b0;
        end
        if (issue_acc) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rf_we_q <= 1'b0;
            rf_ws_q <= '0;
            rf_wd_q <= '0;
            busy_q  <= '0;
        end else begin
            rf_we_q <= rf_we_d;
            rf_ws_q <= rf_ws_d;
            rf_wd_q <= rf_wd_d;
            busy_q  <= busy_d;
        end
    end

    assign rf_we_o = rf_we_q;
    assign rf_ws_o = rf_ws_q;
    assign rf_wd_o = rf_wd_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed self-checking bench for rf_writeback_ctrl.
module tb_rf_writeback_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
    logic        issue_stall;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_rd = '0, mem_rd = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        alu_ready, mem_ready;
    logic        rf_we;
    logic [4:0]  rf_ws;
    logic [31:0] rf_wd;
    logic [31:0] busy;

    int n_cmp  = 0;
    int n_fail = 0;

    rf_writeback_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .issue_valid_i (issue_valid),
        .issue_rs1_i   (issue_rs1),
        .issue_rs2_i   (issue_rs2),
        .issue_rd_i    (issue_rd),
        .issue_stall_o (issue_stall),
        .alu_valid_i   (alu_valid),
        .alu_rd_i      (alu_rd),
        .alu_data_i    (alu_data),
        .alu_ready_o   (alu_ready),
        .mem_valid_i   (mem_valid),
        .mem_rd_i      (mem_rd),
        .mem_data_i    (mem_data),
        .mem_ready_o   (mem_ready),
        .rf_we_o       (rf_we),
        .rf_ws_o       (rf_ws),
        .rf_wd_o       (rf_wd),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: readies forced low even with requests pending.
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        tick();
        #1;
        check("rst_alu_ready", {31'b0, alu_ready}, 32'd0);
        check("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
        check("rst_busy", busy, 32'h0);
        check("rst_we", {31'b0, rf_we}, 32'd0);
        check("rst_ws", {27'b0, rf_ws}, 32'd0);
        check("rst_wd", rf_wd, 32'h0);
        check("rst_stall", {31'b0, issue_stall}, 32'd0);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        tick();
        rst = 1'b0;

        // Contention: ALU first, then alternate.
        tick();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA3;
        mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'hB6;
        #1;
        check("cont0_alu_ready", {31'b0, alu_ready}, 32'd1);
        check("cont0_mem_ready", {31'b0, mem_ready}, 32'd0);
        tick();
        alu_rd = 5'd4; alu_data = 32'hA4;
        #1;
        check("cont1_mem_ready", {31'b0, mem_ready}, 32'd1);
        check("cont1_alu_ready", {31'b0, alu_ready}, 32'd0);
        check("cont1_we", {31'b0, rf_we}, 32'd1);
        check("cont1_ws", {27'b0, rf_ws}, 32'd3);
        check("cont1_wd", rf_wd, 32'hA3);
        tick();
        mem_rd = 5'd7; mem_data = 32'hB7;
        #1;
        check("cont2_alu_ready", {31'b0, alu_ready}, 32'd1);
        check("cont2_ws", {27'b0, rf_ws}, 32'd6);
        check("cont2_wd", rf_wd, 32'hB6);
        tick();
        alu_rd = 5'd3; alu_data = 32'hA5;
        #1;
        check("cont3_mem_ready", {31'b0, mem_ready}, 32'd1);
        check("cont3_alu_ready", {31'b0, alu_ready}, 32'd0);
        check("cont3_ws", {27'b0, rf_ws}, 32'd4);
        tick();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        check("cont4_ws", {27'b0, rf_ws}, 32'd7);
        check("cont4_we", {31'b0, rf_we}, 32'd1);
        tick();
        check("cont5_we_idle", {31'b0, rf_we}, 32'd0);
        check("cont5_ws_hold", {27'b0, rf_ws}, 32'd7);
        check("cont5_busy", busy, 32'h0);

        // RAW stall.
        issue_valid = 1'b1; issue_rd = 5'd5; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
        #1;
        check("raw_issue5_stall", {31'b0, issue_stall}, 32'd0);
        tick();
        check("raw_busy5", busy, 32'h20);
        issue_rd = 5'd10; issue_rs1 = 5'd5;
        #1;
        check("raw_dep_stall", {31'b0, issue_stall}, 32'd1);
        tick();
        check("raw_busy_held", busy, 32'h20);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        check("raw_alu_ready", {31'b0, alu_ready}, 32'd1);
        check("raw_stall_N", {31'b0, issue_stall}, 32'd1);
        tick();
        alu_valid = 1'b0;
        check("raw_we_N1", {31'b0, rf_we}, 32'd1);
        check("raw_ws_N1", {27'b0, rf_ws}, 32'd5);
        check("raw_wd_N1", rf_wd, 32'hDEADBEEF);
        check("raw_busy_N1", busy, 32'h20);
        check("raw_stall_N1", {31'b0, issue_stall}, 32'd1);
        tick();
        check("raw_busy_N2", busy, 32'h0);
        check("raw_stall_N2", {31'b0, issue_stall}, 32'd0);
        tick();
        check("raw_busy10", busy, 32'h400);

        // WAW stall.
        issue_rd = 5'd9; issue_rs1 = 5'd0;
        #1;
        check("waw_first_stall", {31'b0, issue_stall}, 32'd0);
        tick();
        check("waw_busy", busy, 32'h600);
        #1;
        check("waw_second_stall", {31'b0, issue_stall}, 32'd1);
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
        #1;
        check("waw_mem_ready", {31'b0, mem_ready}, 32'd1);
        tick();
        mem_valid = 1'b0;
        check("waw_ws", {27'b0, rf_ws}, 32'd9);
        check("waw_stall_commit", {31'b0, issue_stall}, 32'd1);
        tick();
        check("waw_busy_clr", busy, 32'h400);
        check("waw_accept", {31'b0, issue_stall}, 32'd0);
        tick();
        issue_valid = 1'b0;
        check("waw_busy_reset", busy, 32'h600);

        // x0 handling.
        issue_valid = 1'b1; issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
        #1;
        check("x0_issue_stall", {31'b0, issue_stall}, 32'd0);
        tick();
        issue_valid = 1'b0;
        check("x0_busy", busy, 32'h600);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        #1;
        check("x0_alu_ready", {31'b0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        check("x0_we", {31'b0, rf_we}, 32'd0);
        check("x0_ws", {27'b0, rf_ws}, 32'd0);

        // Spurious writeback to non-busy x12.
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'h1;
        tick();
        mem_valid = 1'b0;
        check("spur_we", {31'b0, rf_we}, 32'd1);
        check("spur_ws", {27'b0, rf_ws}, 32'd12);
        check("spur_wd", rf_wd, 32'h1);
        tick();
        check("spur_busy", busy, 32'h600);

        // Drain x9/x10 (last grant MEM, so ALU first), then build busy = 0x30.
        alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h9;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA;
        #1;
        check("drain_alu_first", {31'b0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        tick();
        mem_valid = 1'b0;
        tick();
        check("drain_busy", busy, 32'h0);
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        issue_rd = 5'd5;
        tick();
        issue_valid = 1'b0;
        check("pre_rst_busy", busy, 32'h30);
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
        tick();
        check("pre_rst_we", {31'b0, rf_we}, 32'd1);

        // Asynchronous reset mid-operation.
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 32'h0);
        check("mid_rst_we", {31'b0, rf_we}, 32'd0);
        check("mid_rst_ws", {27'b0, rf_ws}, 32'd0);
        check("mid_rst_wd", rf_wd, 32'h0);
        check("mid_rst_alu_ready", {31'b0, alu_ready}, 32'd0);
        alu_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_we", {31'b0, rf_we}, 32'd0);
        check("post_rst_busy", busy, 32'h0);
        alu_valid = 1'b1; mem_valid = 1'b1;
        #1;
        check("post_rst_alu_wins", {31'b0, alu_ready}, 32'd1);
        check("post_rst_mem_wait", {31'b0, mem_ready}, 32'd0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
